// File: rtl/mpmc10_read_cache_if.sv
// Bus bundle for the multi-port read cache: fill/invalidate side and per-port read side.
interface mpmc10_read_cache_if #(
  parameter int unsigned NPORTS     = 8,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                         wr;
  logic [ADDR_WIDTH-1:0]        wadr;
  logic [LINE_WIDTH-1:0]        wdat;
  logic                         inv;
  logic                         inv_all;
  logic                         inv_busy;
  logic [NPORTS-1:0]            rreq;
  logic [NPORTS*ADDR_WIDTH-1:0] radr;
  logic [NPORTS-1:0]            rvalid;
  logic [NPORTS*LINE_WIDTH-1:0] rdat;
  logic [NPORTS-1:0]            hit;

  modport master (
    output wr, wadr, wdat, inv, inv_all, rreq, radr,
    input  inv_busy, rvalid, rdat, hit
  );

  modport slave (
    input  wr, wadr, wdat, inv, inv_all, rreq, radr,
    output inv_busy, rvalid, rdat, hit
  );
endinterface

// File: rtl/mpmc10_read_cache.sv
// Two-way set-associative multi-port read cache with line fill, single-line invalidate and a
// full-cache invalidate sweep. Reads have a fixed two-cycle latency on every port.
module mpmc10_read_cache #(
  parameter int unsigned NPORTS     = 8,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned SETS       = 1024,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  mpmc10_read_cache_if.slave bus
);
  localparam int unsigned OFS  = $clog2(LINE_WIDTH / 8);
  localparam int unsigned IDX  = $clog2(SETS);
  localparam int unsigned TAGW = ADDR_WIDTH - IDX - OFS;

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e         state_q;
  logic [IDX-1:0] cnt_q;

  // Line/tag storage has no reset; valid and LRU do.
  logic [LINE_WIDTH-1:0] line_mem [2][SETS];
  logic [TAGW-1:0]       tag_mem  [2][SETS];
  logic [SETS-1:0]       valid_q  [2];
  logic [SETS-1:0]       lru_q;

  // Fill/invalidate side decode.
  logic [IDX-1:0]  w_idx;
  logic [TAGW-1:0] w_tag;
  logic [1:0]      w_match;
  logic            fill_way;
  logic            idle;
  logic            do_fill;
  logic            do_inv;

  // Read pipeline: stage 1 holds the sampled request, stage 2 the lookup result.
  logic [NPORTS-1:0]     s1_req;
  logic [IDX-1:0]        s1_idx [NPORTS];
  logic [TAGW-1:0]       s1_tag [NPORTS];
  logic [NPORTS-1:0]     lk_m0, lk_m1, lk_hit, lk_way;
  logic [LINE_WIDTH-1:0] lk_dat [NPORTS];
  logic [NPORTS-1:0]     s2_valid, s2_hit;
  logic [LINE_WIDTH-1:0] s2_dat [NPORTS];
  logic [NPORTS-1:0]     rvalid_q, hit_q;
  logic [NPORTS*LINE_WIDTH-1:0] rdat_q;
  logic [OFS-1:0]        unused_ofs;

  assign w_idx   = bus.wadr[OFS +: IDX];
  assign w_tag   = bus.wadr[IDX+OFS +: TAGW];
  assign idle    = (state_q == StIdle);
  assign do_fill = bus.wr && idle;
  assign do_inv  = bus.inv && !bus.wr && idle;

  assign bus.inv_busy = (state_q == StSweep);
  assign bus.rvalid   = rvalid_q;
  assign bus.hit      = hit_q;
  assign bus.rdat     = rdat_q;

  // Byte-offset bits never take part in lookup.
  always_comb begin
    unused_ofs = bus.wadr[OFS-1:0];
    for (int p = 0; p < int'(NPORTS); p++) begin
      unused_ofs = unused_ofs ^ bus.radr[p*ADDR_WIDTH +: OFS];
    end
  end

  // Fill victim: matching way, else first invalid way, else the LRU way.
  always_comb begin
    w_match[0] = valid_q[0][w_idx] && (tag_mem[0][w_idx] == w_tag);
    w_match[1] = valid_q[1][w_idx] && (tag_mem[1][w_idx] == w_tag);
    if (w_match[0])             fill_way = 1'b0;
    else if (w_match[1])        fill_way = 1'b1;
    else if (!valid_q[0][w_idx]) fill_way = 1'b0;
    else if (!valid_q[1][w_idx]) fill_way = 1'b1;
    else                        fill_way = lru_q[w_idx];
  end

  // Tag lookup for every port; sees all fills up to and including the sampling edge.
  always_comb begin
    lk_m0  = '0;
    lk_m1  = '0;
    lk_hit = '0;
    lk_way = '0;
    for (int p = 0; p < int'(NPORTS); p++) begin
      lk_dat[p] = '0;
      lk_m0[p]  = valid_q[0][s1_idx[p]] && (tag_mem[0][s1_idx[p]] == s1_tag[p]);
      lk_m1[p]  = valid_q[1][s1_idx[p]] && (tag_mem[1][s1_idx[p]] == s1_tag[p]);
      lk_hit[p] = s1_req[p] && idle && (lk_m0[p] || lk_m1[p]);
      lk_way[p] = ~lk_m0[p];
      if (lk_hit[p]) begin
        lk_dat[p] = lk_m0[p] ? line_mem[0][s1_idx[p]] : line_mem[1][s1_idx[p]];
      end
    end
  end

  // Line and tag storage writes.
  always_ff @(posedge clk) begin
    if (do_fill) begin
      line_mem[fill_way][w_idx] <= bus.wdat;
      tag_mem[fill_way][w_idx]  <= w_tag;
    end
  end

  // Valid/LRU maintenance and the invalidate-sweep FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
      state_q    <= StIdle;
      cnt_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Descending so the lowest-numbered hitting port has the final word.
          for (int p = int'(NPORTS) - 1; p >= 0; p--) begin
            if (lk_hit[p]) lru_q[s1_idx[p]] <= ~lk_way[p];
          end
          // A fill comes last so it overrides read-driven LRU updates.
          if (do_fill) begin
            valid_q[fill_way][w_idx] <= 1'b1;
            lru_q[w_idx]             <= ~fill_way;
          end else if (do_inv) begin
            if (w_match[0]) valid_q[0][w_idx] <= 1'b0;
            if (w_match[1]) valid_q[1][w_idx] <= 1'b0;
          end
          if (bus.inv_all) begin
            state_q <= StSweep;
            cnt_q   <= '0;
          end
        end
        StSweep: begin
          valid_q[0][cnt_q] <= 1'b0;
          valid_q[1][cnt_q] <= 1'b0;
          lru_q[cnt_q]      <= 1'b0;
          if (cnt_q == IDX'(SETS - 1)) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read pipeline: sample, register lookup result, present result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_req   <= '0;
      s2_valid <= '0;
      s2_hit   <= '0;
      rvalid_q <= '0;
      hit_q    <= '0;
      rdat_q   <= '0;
      for (int p = 0; p < int'(NPORTS); p++) begin
        s1_idx[p] <= '0;
        s1_tag[p] <= '0;
        s2_dat[p] <= '0;
      end
    end else begin
      s1_req   <= bus.rreq;
      s2_valid <= s1_req;
      s2_hit   <= lk_hit;
      rvalid_q <= s2_valid;
      hit_q    <= s2_hit & s2_valid;
      for (int p = 0; p < int'(NPORTS); p++) begin
        s1_idx[p] <= bus.radr[p*ADDR_WIDTH+OFS +: IDX];
        s1_tag[p] <= bus.radr[p*ADDR_WIDTH+IDX+OFS +: TAGW];
        s2_dat[p] <= lk_dat[p];
        if (s2_valid[p]) rdat_q[p*LINE_WIDTH +: LINE_WIDTH] <= s2_dat[p];
      end
    end
  end
endmodule

// File: doc/mpmc10_read_cache.md
MPMC10_READ_CACHE -- requirements
Module: mpmc10_read_cache

Interface
REQ-001 Parameter NPORTS, default 8: number of read ports.
REQ-002 Parameter LINE_WIDTH, default 128: line width in bits, a power of two >= 8; OFS = log2(LINE_WIDTH/8).
REQ-003 Parameter SETS, default 1024: sets per way, a power of two; IDX = log2(SETS).
REQ-004 Parameter ADDR_WIDTH, default 32: byte-address width; TAGW = ADDR_WIDTH-IDX-OFS.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 wr  in  1  line fill strobe.
REQ-009 wadr  in  ADDR_WIDTH  fill/invalidate byte address.
REQ-010 wdat  in  LINE_WIDTH  fill data.
REQ-011 inv  in  1  single-line invalidate strobe at wadr.
REQ-012 inv_all  in  1  start full-cache invalidate sweep.
REQ-013 inv_busy  out  1  sweep in progress.
REQ-014 rreq  in  NPORTS  per-port read request.
REQ-015 radr  in  NPORTS*ADDR_WIDTH  per-port address; port p at bits [p*ADDR_WIDTH +: ADDR_WIDTH].
REQ-016 rvalid  out  NPORTS  per-port result strobe.
REQ-017 rdat  out  NPORTS*LINE_WIDTH  per-port line data, packed as radr.
REQ-018 hit  out  NPORTS  per-port hit flag, qualified by rvalid.

Function
REQ-019 Organisation SHALL be 2-way set-associative: per way, SETS lines of LINE_WIDTH, tags of TAGW, a valid bit per line; one LRU bit per set (value = way to replace next).
REQ-020 Index = adr[IDX+OFS-1:OFS]; tag = adr[ADDR_WIDTH-1:IDX+OFS]; offset bits ignored.
REQ-021 Reads: rreq[p] sampled at edge N -> rvalid[p] high for exactly one cycle after edge N+2; fixed latency 2, fully pipelined, one request per port per cycle, no back-pressure.
REQ-022 hit[p] = 1 iff a way in the set is valid with matching tag; rdat[p] = that way's line on hit, 0 on miss.
REQ-023 rvalid=0 cycles: hit=0, rdat holds its last value.
REQ-024 Read at edge N SHALL observe all fills/invalidates sampled at edges <= N and none sampled at edge N+1 or later.
REQ-025 Fill (wr): valid way with matching tag -> overwrite that way; else lowest-numbered invalid way; else way selected by LRU; tag, data written, valid set.
REQ-026 LRU on fill: set to the other way than the one filled.
REQ-027 LRU on read hit (evaluated at result stage): set to the other way than the hit way; multiple ports hitting one set -> lowest-numbered port wins; a fill to the same set in the same cycle overrides read updates.
REQ-028 inv: clears valid of the way matching wadr's tag; miss -> no change; LRU unchanged.
REQ-029 wr and inv in the same cycle: wr performed, inv ignored.
REQ-030 Sweep FSM states IDLE, SWEEP; IDLE --inv_all--> SWEEP with counter=0; SWEEP clears both valid bits and LRU of set[counter] per cycle, increments counter; after set SETS-1 returns to IDLE.
REQ-031 inv_busy high exactly in SWEEP: SETS cycles, starting the cycle after inv_all is sampled.
REQ-032 While inv_busy: wr, inv, inv_all ignored (dropped, no queueing); reads accepted with hit forced 0.
REQ-033 Address arithmetic SHALL be unsigned; sweep counter wraps only by FSM exit, never silently.

Reset
REQ-034 rst asserted: all valid bits 0, all LRU bits 0, FSM IDLE, counter 0, inv_busy 0, rvalid 0, hit 0, rdat 0, read pipeline flushed; line and tag storage contents unspecified.
REQ-035 rst asserted during SWEEP or with reads in flight: sweep aborted, in-flight reads dropped (no rvalid).
REQ-036 First edge after rst deasserts: fully operational.

Verification
REQ-037 After reset, port 0 reads 0x1000 -> rvalid[0] two cycles later, hit=0, rdat=0.
REQ-038 Fill 0x1000 data A; next cycle ports 0..7 all read 0x1008 -> all rvalid after 2 cycles, hit=1, rdat=A.
REQ-039 Fill 0x1000 (A), 0x5000 (B, same set, default params), read 0x1000 (hit way0, LRU->1), fill 0x9000 (C) -> C replaces B: 0x5000 miss, 0x1000 and 0x9000 hit.
REQ-040 Fill 0x2000, then wr=1 and inv=1 same cycle at 0x2000 with data D -> read hit, rdat=D; then inv alone -> read miss.
REQ-041 Fill 8 lines, pulse inv_all -> inv_busy high exactly 1024 cycles; wr during sweep dropped; after done all reads miss.
REQ-042 Pulse inv_all, assert rst at sweep cycle 100 -> inv_busy 0 immediately, all valid 0, fills work on first post-reset edge.
